// File: rtl/tc_pl_cap_gain_spi_tx.sv
// Byte-serial SPI master for the gain DAC: consecutive stx bytes form one CSn-low frame.
// Define TC_PL_GAIN_SPI_CPOL1_EN for an idle-high SCLK (mode 2); default is mode 0.
module tc_pl_cap_gain_spi_tx #(
  parameter int SPI0_0   = 8,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              stx_idle,
  output logic              stx_dreq,
  input  logic              stx_valid,
  input  logic [SPI0_0-1:0] stx_data,
  output logic              spi_sclk,
  output logic              spi_csn,
  output logic              spi_mosi
);

  localparam int BIT_W   = (SPI0_0 > 1) ? $clog2(SPI0_0) : 1;
  localparam int SEQ_MAX = (CS_SETUP > CS_HOLD) ?
                           ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE) :
                           ((CS_HOLD  > CS_IDLE) ? CS_HOLD  : CS_IDLE);
  localparam int SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;

  localparam logic [7:0]       DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(SPI0_0 - 1);
  localparam logic [SEQ_W-1:0] SETUP_LAST = SEQ_W'(CS_SETUP - 1);
  localparam logic [SEQ_W-1:0] HOLD_LAST  = SEQ_W'(CS_HOLD - 1);
  localparam logic [SEQ_W-1:0] IDLE_LAST  = SEQ_W'(CS_IDLE - 1);

`ifdef TC_PL_GAIN_SPI_CPOL1_EN
  localparam logic CPOL = 1'b1;
`else
  localparam logic CPOL = 1'b0;
`endif

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_RECOV = 3'd4;

  logic [2:0]        r_state;
  logic [SEQ_W-1:0]  r_seq;
  logic [7:0]        r_div;
  logic              r_phase;
  logic [BIT_W-1:0]  r_bit;
  logic              r_pend;
  logic [SPI0_0-1:0] r_shift;
  logic [SPI0_0-1:0] r_nxt;
  logic              r_idle;
  logic              r_dreq;
  logic              r_sclk;
  logic              r_csn;
  logic              r_mosi;

  logic [2:0]        w_state_n;
  logic [SEQ_W-1:0]  w_seq_n;
  logic [7:0]        w_div_n;
  logic              w_phase_n;
  logic [BIT_W-1:0]  w_bit_n;
  logic              w_pend_n;
  logic [SPI0_0-1:0] w_shift_n;
  logic [SPI0_0-1:0] w_nxt_n;
  logic              w_win;
  logic              w_cap;
  logic              w_more;
  logic [SPI0_0-1:0] w_more_data;
  logic              w_idle_n;
  logic              w_dreq_n;
  logic              w_sclk_n;
  logic              w_csn_n;
  logic              w_mosi_n;

  // Next-state: the capture window is the last bit minus its first (dreq) cycle
  always_comb begin
    w_state_n = r_state;
    w_seq_n   = r_seq;
    w_div_n   = r_div;
    w_phase_n = r_phase;
    w_bit_n   = r_bit;
    w_pend_n  = r_pend;
    w_shift_n = r_shift;
    w_nxt_n   = r_nxt;

    w_win = (r_state == ST_SHIFT) && (r_bit == BIT_LAST) &&
            (r_phase || (r_div != 8'd0));
    w_cap = w_win && stx_valid && !r_pend;
    if (w_cap) begin
      w_nxt_n  = stx_data;
      w_pend_n = 1'b1;
    end
    // A byte captured on the final cycle of the bit must still chain
    w_more      = r_pend || w_cap;
    w_more_data = r_pend ? r_nxt : stx_data;

    case (r_state)
      ST_IDLE: begin
        if (stx_valid) begin
          w_state_n = ST_SETUP;
          w_shift_n = stx_data;
          w_seq_n   = '0;
        end
      end
      ST_SETUP: begin
        if (r_seq == SETUP_LAST) begin
          w_state_n = ST_SHIFT;
          w_div_n   = 8'd0;
          w_phase_n = 1'b0;
          w_bit_n   = '0;
        end else begin
          w_seq_n = r_seq + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (r_div == DIV_LAST) begin
          w_div_n = 8'd0;
          if (!r_phase) begin
            w_phase_n = 1'b1;
          end else begin
            w_phase_n = 1'b0;
            if (r_bit == BIT_LAST) begin
              if (w_more) begin
                w_shift_n = w_more_data;
                w_pend_n  = 1'b0;
                w_bit_n   = '0;
              end else begin
                w_state_n = ST_HOLD;
                w_seq_n   = '0;
              end
            end else begin
              w_bit_n   = r_bit + 1'b1;
              w_shift_n = r_shift << 1;
            end
          end
        end else begin
          w_div_n = r_div + 8'd1;
        end
      end
      ST_HOLD: begin
        if (r_seq == HOLD_LAST) begin
          w_state_n = ST_RECOV;
          w_seq_n   = '0;
        end else begin
          w_seq_n = r_seq + 1'b1;
        end
      end
      ST_RECOV: begin
        if (r_seq == IDLE_LAST) begin
          w_state_n = ST_IDLE;
          w_seq_n   = '0;
        end else begin
          w_seq_n = r_seq + 1'b1;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_seq_n   = '0;
        w_pend_n  = 1'b0;
      end
    endcase
  end

  // Output decode from the next state so every pin comes straight off a flop
  always_comb begin
    w_idle_n = (w_state_n == ST_IDLE);
    w_csn_n  = !((w_state_n == ST_SETUP) || (w_state_n == ST_SHIFT) ||
                 (w_state_n == ST_HOLD));
    w_sclk_n = CPOL ^ ((w_state_n == ST_SHIFT) && w_phase_n);
    w_dreq_n = (w_state_n == ST_SHIFT) && (w_bit_n == BIT_LAST) &&
               !w_phase_n && (w_div_n == 8'd0);
    case (w_state_n)
      ST_SETUP, ST_SHIFT: w_mosi_n = w_shift_n[SPI0_0-1];
      ST_HOLD:            w_mosi_n = r_mosi;
      default:            w_mosi_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_seq   <= '0;
      r_div   <= 8'd0;
      r_phase <= 1'b0;
      r_bit   <= '0;
      r_pend  <= 1'b0;
      r_idle  <= 1'b1;
      r_dreq  <= 1'b0;
      r_sclk  <= CPOL;
      r_csn   <= 1'b1;
      r_mosi  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_seq   <= w_seq_n;
      r_div   <= w_div_n;
      r_phase <= w_phase_n;
      r_bit   <= w_bit_n;
      r_pend  <= w_pend_n;
      r_idle  <= w_idle_n;
      r_dreq  <= w_dreq_n;
      r_sclk  <= w_sclk_n;
      r_csn   <= w_csn_n;
      r_mosi  <= w_mosi_n;
    end
  end

  always_ff @(posedge clk) begin
    r_shift <= w_shift_n;
    r_nxt   <= w_nxt_n;
  end

  assign stx_idle = r_idle;
  assign stx_dreq = r_dreq;
  assign spi_sclk = r_sclk;
  assign spi_csn  = r_csn;
  assign spi_mosi = r_mosi;

endmodule

// File: tb/tb_tc_pl_cap_gain_spi_tx.sv
// Bench for tc_pl_cap_gain_spi_tx: frame-timing model plus per-frame decoded-pattern checks.
module tb_tc_pl_cap_gain_spi_tx;

  localparam int W     = 8;
  localparam int D     = 4;
  localparam int CSS   = 2;
  localparam int CSH   = 2;
  localparam int CSI   = 4;
  localparam int BITP  = 2 * D;
  localparam int BYTEP = W * BITP;

`ifdef TC_PL_GAIN_SPI_CPOL1_EN
  localparam logic CPOL = 1'b1;
`else
  localparam logic CPOL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stx_valid = 1'b0;
  logic [7:0] stx_data = 8'h00;
  logic       stx_idle, stx_dreq, spi_sclk, spi_csn, spi_mosi;

  always #5 clk = ~clk;

  tc_pl_cap_gain_spi_tx dut (
    .clk       (clk),
    .rst       (rst),
    .stx_idle  (stx_idle),
    .stx_dreq  (stx_dreq),
    .stx_valid (stx_valid),
    .stx_data  (stx_data),
    .spi_sclk  (spi_sclk),
    .spi_csn   (spi_csn),
    .spi_mosi  (spi_mosi)
  );

  int n_chk = 0;
  int n_err = 0;

  int          exp_len;
  int          exp_bits;
  int          exp_dreq;
  logic [63:0] exp_word;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: frame model compared every cycle, plus per-frame measurements
  initial begin : mon
    int mode, k, nb, rec, s, b, r, bt, ph, lend;
    logic [7:0] bytes[$];
    logic [7:0] cur;
    logic seen, prev_rst, prev_csn, prev_sclk, prev_idle, win;
    logic e_idle, e_dreq, e_sclk, e_csn, e_mosi;
    int f_len, f_bits, f_dreq, rec_cnt;
    logic [63:0] f_word;
    logic f_abort, in_rec;
    mode = 0; k = 0; nb = 0; rec = 0;
    seen = 1'b0; prev_rst = 1'b0; prev_csn = 1'b1; prev_sclk = CPOL; prev_idle = 1'b1;
    f_len = 0; f_bits = 0; f_dreq = 0; rec_cnt = 0; f_word = '0;
    f_abort = 1'b0; in_rec = 1'b0;
    forever begin
      @(negedge clk);
      e_idle = 1'b1; e_dreq = 1'b0; e_sclk = CPOL; e_csn = 1'b1; e_mosi = 1'b0;
      win = 1'b0;
      if (mode == 1) begin
        e_idle = 1'b0; e_csn = 1'b0;
        lend = CSS + nb * BYTEP;
        if (k < CSS) begin
          cur = bytes[0];
          e_mosi = cur[W-1];
        end else if (k < lend) begin
          s  = k - CSS;
          b  = s / BYTEP;
          r  = s % BYTEP;
          bt = r / BITP;
          ph = r % BITP;
          cur = bytes[b];
          e_mosi = cur[W-1-bt];
          e_sclk = CPOL ^ (ph >= D);
          e_dreq = (bt == W-1) && (ph == 0);
          win    = (bt == W-1) && (ph >= 1) && (b == nb-1);
        end else begin
          cur = bytes[nb-1];
          e_mosi = cur[0];
        end
      end else if (mode == 2) begin
        e_idle = 1'b0;
      end

      if (seen) begin
        chk("model_idle", 64'(stx_idle), 64'(e_idle));
        chk("model_dreq", 64'(stx_dreq), 64'(e_dreq));
        chk("model_csn",  64'(spi_csn),  64'(e_csn));
        chk("model_sclk", 64'(spi_sclk), 64'(e_sclk));
        chk("model_mosi", 64'(spi_mosi), 64'(e_mosi));
        if (prev_rst) begin
          chk("rst_idle", 64'(stx_idle), 64'd1);
          chk("rst_dreq", 64'(stx_dreq), 64'd0);
          chk("rst_csn",  64'(spi_csn),  64'd1);
          chk("rst_sclk", 64'(spi_sclk), 64'(CPOL));
          chk("rst_mosi", 64'(spi_mosi), 64'd0);
        end
        if (prev_csn === 1'b1 && spi_csn === 1'b0) begin
          f_len = 0; f_bits = 0; f_dreq = 0; f_word = '0; f_abort = 1'b0;
        end
        if (spi_csn === 1'b0) begin
          f_len++;
          if (spi_sclk !== prev_sclk && spi_sclk === ~CPOL) begin
            f_word = {f_word[62:0], spi_mosi};
            f_bits++;
          end
          if (rst) f_abort = 1'b1;
        end
        if (stx_dreq === 1'b1) f_dreq++;
        if (prev_csn === 1'b0 && spi_csn === 1'b1 && !f_abort) begin
          chk("frame_csn_len", 64'(f_len),  64'(exp_len));
          chk("frame_bits",    64'(f_bits), 64'(exp_bits));
          chk("frame_word",    f_word,      exp_word);
          chk("frame_dreqs",   64'(f_dreq), 64'(exp_dreq));
          in_rec = 1'b1; rec_cnt = 0;
        end
        if (in_rec) begin
          if (stx_idle === 1'b1) begin
            chk("recov_len", 64'(rec_cnt), 64'(CSI));
            in_rec = 1'b0;
          end else if (spi_csn === 1'b1) begin
            rec_cnt++;
          end
        end
      end

      prev_rst = rst;
      if (rst) seen = 1'b1;
      if (rst) begin
        mode = 0; in_rec = 1'b0;
      end else if (mode == 0) begin
        if (stx_valid) begin
          mode = 1; k = 0; nb = 1;
          bytes.delete();
          bytes.push_back(stx_data);
        end
      end else if (mode == 1) begin
        if (win && stx_valid) begin
          bytes.push_back(stx_data);
          nb++;
        end
        k++;
        if (k >= CSS + nb * BYTEP + CSH) begin
          mode = 2; rec = 0;
        end
      end else begin
        rec++;
        if (rec == CSI) mode = 0;
      end
      prev_csn = spi_csn; prev_sclk = spi_sclk; prev_idle = stx_idle;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] b);
    stx_valid = 1'b1;
    stx_data  = b;
    tick();
    stx_valid = 1'b0;
  endtask

  task automatic wait_dreq();
    for (int i = 0; i < 2000; i++) begin
      if (stx_dreq === 1'b1) return;
      tick();
    end
    $display("FAIL wait_dreq: got timeout, want dreq pulse (t=%0t)", $time);
    $fatal(1, "timeout");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      if (stx_idle === 1'b1) return;
      tick();
    end
    $display("FAIL wait_idle: got timeout, want idle (t=%0t)", $time);
    $fatal(1, "timeout");
  endtask

  task automatic set_exp(input int len, input int bits, input logic [63:0] word, input int dr);
    exp_len = len; exp_bits = bits; exp_word = word; exp_dreq = dr;
  endtask

  initial begin
    set_exp(0, 0, 64'd0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) tick();

    // single byte, no reply
    set_exp(68, 8, 64'hA5, 1);
    pulse(8'hA5);
    wait_idle();
    tick();

    // three bytes, each reply one cycle after dreq
    set_exp(196, 24, 64'h123456, 3);
    pulse(8'h12);
    wait_dreq(); tick(); pulse(8'h34);
    wait_dreq(); tick(); pulse(8'h56);
    wait_idle();
    tick();

    // late reply lands in HOLD and is ignored
    set_exp(68, 8, 64'h3C, 1);
    pulse(8'h3C);
    wait_dreq();
    repeat (BITP) tick();
    pulse(8'h99);
    wait_idle();
    tick();

    // reply coincident with dreq is ignored
    set_exp(68, 8, 64'hE1, 1);
    pulse(8'hE1);
    wait_dreq();
    pulse(8'h66);
    wait_idle();
    tick();

    // reply on the final cycle of the window still chains
    set_exp(132, 16, 64'h8142, 2);
    pulse(8'h81);
    wait_dreq();
    repeat (BITP - 1) tick();
    pulse(8'h42);
    wait_idle();
    tick();

    // two replies in one window: first wins
    set_exp(132, 16, 64'hC377, 2);
    pulse(8'hC3);
    wait_dreq(); tick(); pulse(8'h77);
    tick(); pulse(8'h88);
    wait_idle();
    tick();

    // reset during bit 3 of byte 2, then a clean frame
    pulse(8'h12);
    wait_dreq(); tick(); pulse(8'h34);
    repeat (32) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2) tick();
    set_exp(68, 8, 64'h5A, 1);
    pulse(8'h5A);
    wait_idle();
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
